// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: round-robin between instruction fetch and load/store
// unit, moving up to four bytes per access over an 8-bit synchronous RAM port.
module mem_arbiter #(
  parameter int AddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_exception_from_rob,
  input  logic                 is_req_from_fc,
  input  logic [AddrWidth-1:0] addr_from_fc,
  output logic                 is_finish_to_fc,
  output logic [31:0]          instr_to_fc,
  input  logic                 is_req_from_lsb,
  input  logic                 is_store_from_lsb,
  input  logic [1:0]           size_from_lsb,
  input  logic [AddrWidth-1:0] addr_from_lsb,
  input  logic [31:0]          data_from_lsb,
  output logic                 is_finish_to_lsb,
  output logic [31:0]          data_to_lsb,
  input  logic [7:0]           mem_din,
  output logic [7:0]           mem_dout,
  output logic [AddrWidth-1:0] mem_a,
  output logic                 mem_wr
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;

  state_t               state;
  logic [2:0]           cnt;
  logic [2:0]           len;
  logic [AddrWidth-1:0] base;
  logic [31:0]          wdata;
  logic [7:0]           rbuf [4];
  logic                 last_lsb;

  logic                 fc_valid;
  logic                 lsb_valid;
  logic                 grant_fc;
  logic                 grant_lsb;
  logic [2:0]           lsb_len;
  logic [2:0]           cnt_nxt;
  logic [AddrWidth-1:0] addr_nxt;
  logic [31:0]          rd_word;

  always_comb begin
    // A requester still showing its finish pulse is the one just served.
    fc_valid  = is_req_from_fc && !is_finish_to_fc;
    lsb_valid = is_req_from_lsb && !is_finish_to_lsb;
    grant_fc  = (state == IDLE) && !is_exception_from_rob && fc_valid
                && (!lsb_valid || last_lsb);
    grant_lsb = (state == IDLE) && !is_exception_from_rob && lsb_valid && !grant_fc;

    case (size_from_lsb)
      2'd0:    lsb_len = 3'd1;
      2'd1:    lsb_len = 3'd2;
      default: lsb_len = 3'd4;
    endcase

    cnt_nxt  = cnt + 3'd1;
    addr_nxt = base + AddrWidth'(cnt_nxt);

    // Last byte arrives on mem_din in the cnt==len cycle; higher bytes stay zero.
    rd_word = {rbuf[3], rbuf[2], rbuf[1], rbuf[0]};
    case (len)
      3'd1:    rd_word[7:0]   = mem_din;
      3'd2:    rd_word[15:8]  = mem_din;
      default: rd_word[31:24] = mem_din;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      len              <= '0;
      base             <= '0;
      wdata            <= '0;
      last_lsb         <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) rbuf[i] <= '0;
      is_finish_to_fc  <= 1'b0;
      is_finish_to_lsb <= 1'b0;
      instr_to_fc      <= '0;
      data_to_lsb      <= '0;
      mem_dout         <= '0;
      mem_a            <= '0;
      mem_wr           <= 1'b0;
    end else begin
      is_finish_to_fc  <= 1'b0;
      is_finish_to_lsb <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          mem_wr   <= 1'b0;
          mem_a    <= '0;
          mem_dout <= '0;
          if (grant_fc) begin
            state    <= FETCH;
            base     <= addr_from_fc;
            len      <= 3'd4;
            last_lsb <= 1'b0;
            mem_a    <= addr_from_fc;
            for (int unsigned i = 0; i < 4; i++) rbuf[i] <= '0;
          end else if (grant_lsb) begin
            base     <= addr_from_lsb;
            len      <= lsb_len;
            wdata    <= data_from_lsb;
            last_lsb <= 1'b1;
            mem_a    <= addr_from_lsb;
            for (int unsigned i = 0; i < 4; i++) rbuf[i] <= '0;
            if (is_store_from_lsb) begin
              state    <= STORE;
              mem_wr   <= 1'b1;
              mem_dout <= data_from_lsb[7:0];
            end else begin
              state <= LOAD;
            end
          end
        end

        FETCH, LOAD: begin
          if (is_exception_from_rob) begin
            state <= IDLE;
            cnt   <= '0;
            mem_a <= '0;
          end else if (cnt == len) begin
            state <= IDLE;
            cnt   <= '0;
            mem_a <= '0;
            if (state == FETCH) begin
              instr_to_fc     <= rd_word;
              is_finish_to_fc <= 1'b1;
            end else begin
              data_to_lsb      <= rd_word;
              is_finish_to_lsb <= 1'b1;
            end
          end else begin
            if (cnt != 3'd0) rbuf[2'(cnt - 3'd1)] <= mem_din;
            cnt   <= cnt_nxt;
            mem_a <= (cnt_nxt < len) ? addr_nxt : '0;
          end
        end

        STORE: begin
          if (cnt == len - 3'd1) begin
            state            <= IDLE;
            cnt              <= '0;
            is_finish_to_lsb <= 1'b1;
            mem_wr           <= 1'b0;
            mem_a            <= '0;
            mem_dout         <= '0;
          end else begin
            cnt      <= cnt_nxt;
            mem_a    <= addr_nxt;
            mem_dout <= wdata[{cnt_nxt[1:0], 3'b000} +: 8];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
